// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-master data memory arbiter.
// Latency: none (types and a combinational address check only).
// Backpressure: not applicable.
package mem_arb_pkg;

    // Arbiter FSM encoding: one transaction walks IDLE -> ACCESS -> RESP.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Owner of the transaction in flight.
    typedef logic owner_t;
    localparam owner_t OWN_M0 = 1'b0;
    localparam owner_t OWN_M1 = 1'b1;

    // A byte address is usable when it is word aligned and inside the attached memory.
    // The address is widened to 64 bits so no out-of-range value can alias into range.
    function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && (addr < (64'(depth) * 64'd4));
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the one not served last.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to sample the grants.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t last,
    output logic   gnt0,
    output logic   gnt1
);

    // On a tie, M0 wins exactly when M1 was the last owner.
    always_comb begin
        gnt0 = req0 & (~req1 | (last == OWN_M1));
        gnt1 = req1 & (~req0 | (last == OWN_M0));
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between M0 (load/store unit) and M1 (debug/DMA).
// Latency: request seen in IDLE -> memory access next cycle -> ack pulse the cycle after.
// Backpressure: requesters hold req stable until ack; only one transaction is in flight.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    state_t        state_q,   state_d;
    owner_t        owner_q,   owner_d;
    owner_t        rr_last_q, rr_last_d;
    logic          we_q,      we_d;
    logic          err_q,     err_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic [DW-1:0] rdata_q,   rdata_d;

    logic          gnt0, gnt1;

    rr_arbiter2 u_rr (
        .req0 (m0_req),
        .req1 (m1_req),
        .last (rr_last_q),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    // Next-state logic: capture the winner in IDLE, sample memory in ACCESS, ack in RESP.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        we_d      = we_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 | gnt1) begin
                    owner_d = gnt1 ? OWN_M1 : OWN_M0;
                    we_d    = gnt1 ? m1_we    : m0_we;
                    addr_d  = gnt1 ? m1_addr  : m0_addr;
                    wdata_d = gnt1 ? m1_wdata : m0_wdata;
                    err_d   = ~addr_ok(64'(gnt1 ? m1_addr : m0_addr), DEPTH);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Stores and rejected requests return zero data.
                rdata_d   = (we_q | err_q) ? '0 : mem_rd;
                rr_last_d = owner_q;
                state_d   = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_M0;
            rr_last_q <= OWN_M1;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            we_q      <= we_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // Outputs decode registered state only, so requests never reach acks or memory combinationally.
    always_comb begin
        mem_a    = '0;
        mem_we   = 1'b0;
        mem_wd   = '0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = '0;
        if (state_q == ACCESS) begin
            mem_a  = addr_q;
            mem_wd = wdata_q;
            mem_we = we_q & ~err_q;
        end
        if (state_q == RESP) begin
            if (owner_q == OWN_M1) begin
                m1_ack   = 1'b1;
                m1_err   = err_q;
                m1_rdata = rdata_q;
            end else begin
                m0_ack   = 1'b1;
                m0_err   = err_q;
                m0_rdata = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] ram [64];

    int checks   = 0;
    int failures = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    int both_cnt = 0;
    int we_cnt   = 0;

    always #5 clk = ~clk;

    data_mem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_rdata (m1_rdata),
        .mem_a    (mem_a),
        .mem_we   (mem_we),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    // Behavioural data_memory: combinational read, write on posedge, word index a/4.
    assign mem_rd = (mem_a < 32'd256) ? ram[mem_a[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_a[7:2]] <= mem_wd;
    end

    // Event monitor sampled away from the active edge.
    always @(negedge clk) begin
        if (m0_ack) ack0_cnt++;
        if (m1_ack) ack1_cnt++;
        if (m0_ack && m1_ack) both_cnt++;
        if (mem_we) we_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_acks_errs"}, 64'({m0_ack, m0_err, m1_ack, m1_err, mem_we}), 64'h0);
        chk({name, "_rdata"}, {m0_rdata, m1_rdata}, 64'h0);
        chk({name, "_mem_bus"}, {mem_a, mem_wd}, 64'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transaction on master m; expects the ack at the second negedge after req is raised.
    task automatic txn(input string name, input logic m, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
        int   cyc;
        logic got;
        @(negedge clk);
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
        end
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 6) begin
            @(negedge clk);
            cyc++;
            got = m ? m1_ack : m0_ack;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_ack required=ack", name);
        end else begin
            chk({name, "_latency"}, 64'(cyc), 64'd2);
            chk({name, "_err"}, 64'(m ? m1_err : m0_err), 64'(exp_err));
            chk({name, "_rdata"}, 64'(m ? m1_rdata : m0_rdata), 64'(exp_rd));
            chk({name, "_other_quiet"},
                64'(m ? {m0_ack, m0_err, m0_rdata} : {m1_ack, m1_err, m1_rdata}), 64'h0);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int own  [4];
        int at   [4];
        int n;
        int cyc;
        int snap0, snap1, snapwe;

        for (int i = 0; i < 64; i++) ram[i] = 32'h1000_0000 + 32'(i);

        vecs[0] = '{"m0_wr_10",   1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{"m0_rd_10",   1'b0, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2] = '{"m1_rd_0e",   1'b1, 1'b0, 32'h0E,  32'h0,        1'b1, 32'h0};
        vecs[3] = '{"m1_rd_100",  1'b1, 1'b0, 32'h100, 32'h0,        1'b1, 32'h0};
        vecs[4] = '{"m1_wr_fc",   1'b1, 1'b1, 32'hFC,  32'h12345678, 1'b0, 32'h0};
        vecs[5] = '{"m0_rd_fc",   1'b0, 1'b0, 32'hFC,  32'h0,        1'b0, 32'h12345678};
        vecs[6] = '{"m1_wr_100",  1'b1, 1'b1, 32'h100, 32'h55555555, 1'b1, 32'h0};
        vecs[7] = '{"m1_wr_0e",   1'b1, 1'b1, 32'h0E,  32'h77777777, 1'b1, 32'h0};
        vecs[8] = '{"m0_rd_0c",   1'b0, 1'b0, 32'h0C,  32'h0,        1'b0, 32'h10000003};
        vecs[9] = '{"m0_rd_00",   1'b0, 1'b0, 32'h00,  32'h0,        1'b0, 32'h10000000};

        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        #12;
        check_outputs_zero("reset");
        do_reset();

        // Table-driven single transactions.
        snapwe = we_cnt;
        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].name, vecs[i].m, vecs[i].we, vecs[i].addr, vecs[i].wd,
                vecs[i].exp_err, vecs[i].exp_rd);
        end
        repeat (2) @(negedge clk);
        chk("legal_write_count", 64'(we_cnt - snapwe), 64'd2);
        chk("ram_word3_untouched", 64'(ram[3]), 64'h10000003);
        chk("ram_word0_no_alias", 64'(ram[0]), 64'h10000000);
        chk("ram_last_word", 64'(ram[63]), 64'h12345678);

        // Fairness: both requesters continuously high after reset.
        do_reset();
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hFC;
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (m0_ack || m1_ack) begin
                own[n] = m1_ack ? 1 : 0;
                at[n]  = cyc;
                chk($sformatf("rr_rdata_%0d", n), 64'(m1_ack ? m1_rdata : m0_rdata),
                    m1_ack ? 64'h12345678 : 64'hDEADBEEF);
                n++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        if (n < 4) begin
            checks++;
            failures++;
            $display("FAIL rr_timeout actual=%0d_acks required=4", n);
        end else begin
            chk("rr_first_latency", 64'(at[0]), 64'd2);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rr_owner_%0d", k), 64'(own[k]), 64'(k % 2));
                if (k > 0) chk($sformatf("rr_spacing_%0d", k), 64'(at[k] - at[k-1]), 64'd3);
            end
        end

        // Reset during the ACCESS cycle of a write.
        repeat (2) @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("rst_pre_mem_we", 64'({mem_we, mem_a}), {31'h0, 1'b1, 32'h20});
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        m0_req = 1'b0;
        @(negedge clk);
        check_outputs_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        snap0 = ack0_cnt;
        repeat (5) @(negedge clk);
        chk("rst_no_ack", 64'(ack0_cnt - snap0), 64'd0);
        chk("rst_ram_20_kept", 64'(ram[8]), 64'h10000008);

        // M0 pulses req for one cycle while M1 owns the bus.
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hFC;
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
        snap0 = ack0_cnt;
        snap1 = ack1_cnt;
        @(negedge clk);
        chk("drop_m1_ack", 64'({m1_ack, m1_err, m1_rdata}), {31'h0, 1'b1, 1'b0, 32'h12345678});
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (6) @(negedge clk);
        chk("drop_m0_not_served", 64'(ack0_cnt - snap0), 64'd0);
        chk("drop_m1_single_ack", 64'(ack1_cnt - snap1), 64'd1);

        chk("never_both_acks", 64'(both_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
